// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential 32-bit divider.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam int unsigned DIV_W    = 32;
  localparam logic [5:0]  DIV_LAST = 6'd32;

  function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on the {remainder, dividend, quotient-bit} shift register.
module div_step
  import div_seq_pkg::*;
(
  input  logic [2*DIV_W:0]   dividend_in,
  input  logic [DIV_W-1:0]   divisor,
  output logic [2*DIV_W:0]   dividend_out
);

  logic [DIV_W:0] diff;

  always_comb begin
    diff = dividend_in[2*DIV_W:DIV_W] - {1'b0, divisor};
    if (diff[DIV_W]) begin
      dividend_out = {dividend_in[2*DIV_W-1:0], 1'b0};
    end else begin
      dividend_out = {diff[DIV_W-1:0], dividend_in[DIV_W-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned 32-bit divider for the EX stage; result is {remainder, quotient}.
module div_seq
  import div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  div_state_e  state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [64:0] dividend, dividend_n, step_out;
  logic [31:0] divisor, divisor_n;
  logic        sign1, sign1_n, sign2, sign2_n, sgn, sgn_n;
  logic [63:0] result_n;
  logic        ready_n;
  logic [31:0] quot, rem;

  div_step u_step (
    .dividend_in  (dividend),
    .divisor      (divisor),
    .dividend_out (step_out)
  );

  always_comb begin
    stallreq_o = start_i & ~ready_o & ~annul_i;
  end

  // Quotient lives in [31:0]; remainder was left one bit up at [64:33] by the last step.
  always_comb begin
    quot = neg_if(dividend[31:0], sgn & (sign1 ^ sign2));
    rem  = neg_if(dividend[64:33], sgn & sign1);
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    dividend_n = dividend;
    divisor_n  = divisor;
    sign1_n    = sign1;
    sign2_n    = sign2;
    sgn_n      = sgn;
    result_n   = result_o;
    ready_n    = ready_o;
    case (state)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          sgn_n      = signed_div_i;
          sign1_n    = signed_div_i & opdata1_i[31];
          sign2_n    = signed_div_i & opdata2_i[31];
          divisor_n  = neg_if(opdata2_i, signed_div_i & opdata2_i[31]);
          dividend_n = {32'd0, neg_if(opdata1_i, signed_div_i & opdata1_i[31]), 1'b0};
          cnt_n      = '0;
          state_n    = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
        end
      end
      DIV_BYZERO: begin
        result_n = '0;
        if (annul_i) begin
          state_n = DIV_FREE;
          ready_n = DIV_RESULT_NOT_READY;
        end else begin
          state_n = DIV_END;
          ready_n = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_n  = DIV_FREE;
          ready_n  = DIV_RESULT_NOT_READY;
          result_n = '0;
        end else if (cnt != DIV_LAST) begin
          dividend_n = step_out;
          cnt_n      = cnt + 6'd1;
        end else begin
          result_n = {rem, quot};
          ready_n  = DIV_RESULT_READY;
          state_n  = DIV_END;
          cnt_n    = '0;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_n  = DIV_FREE;
          ready_n  = DIV_RESULT_NOT_READY;
          result_n = '0;
        end
      end
      default: state_n = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      sgn      <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dividend <= dividend_n;
      divisor  <= divisor_n;
      sign1    <= sign1_n;
      sign2    <= sign2_n;
      sgn      <= sgn_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule
